// File: rtl/id_decode.sv
// id_decode: RV32I decode stage. Combinational field expansion of the fetched
// word, followed by a registered output slot backed by a one-entry skid buffer
// so that o_ready can be a plain register while throughput stays at one word
// per cycle.
module id_decode #(
  parameter logic [5:0] ILLEGAL_OP = 6'd63
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [5:0]  o_op,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic        o_rs1_used,
  output logic        o_rs2_used,
  output logic        o_illegal
);

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        rs1_used;
    logic        rs2_used;
    logic        illegal;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // Raw instruction fields and immediate candidates
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign rd_f   = i_instr[11:7];
  assign rs1_f  = i_instr[19:15];
  assign rs2_f  = i_instr[24:20];
  assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u  = {i_instr[31:12], 12'b0};
  assign imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, i_instr[24:20]};

  logic [5:0]  d_op;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm;
  logic        d_rs1_used, d_rs2_used, d_legal;
  dec_t        dec;

  // Decode the incoming word; anything not matched stays illegal with zeroed fields
  always_comb begin
    d_op = ILLEGAL_OP; d_rd = '0; d_rs1 = '0; d_rs2 = '0; d_imm = '0;
    d_rs1_used = 1'b0; d_rs2_used = 1'b0; d_legal = 1'b0;
    case (opcode)
      7'b0110111: begin d_legal = 1'b1; d_op = 6'd0; d_rd = rd_f; d_imm = imm_u; end
      7'b0010111: begin d_legal = 1'b1; d_op = 6'd1; d_rd = rd_f; d_imm = imm_u; end
      7'b1101111: begin d_legal = 1'b1; d_op = 6'd2; d_rd = rd_f; d_imm = imm_j; end
      7'b1100111: if (funct3 == 3'b000) begin
        d_legal = 1'b1; d_op = 6'd3; d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i; d_rs1_used = 1'b1;
      end
      7'b1100011: begin
        d_rs1 = rs1_f; d_rs2 = rs2_f; d_imm = imm_b; d_rs1_used = 1'b1; d_rs2_used = 1'b1;
        case (funct3)
          3'b000: begin d_legal = 1'b1; d_op = 6'd10; end
          3'b001: begin d_legal = 1'b1; d_op = 6'd11; end
          3'b100: begin d_legal = 1'b1; d_op = 6'd12; end
          3'b101: begin d_legal = 1'b1; d_op = 6'd13; end
          3'b110: begin d_legal = 1'b1; d_op = 6'd14; end
          3'b111: begin d_legal = 1'b1; d_op = 6'd15; end
          default: ;
        endcase
      end
      7'b0000011: begin
        d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i; d_rs1_used = 1'b1;
        case (funct3)
          3'b000: begin d_legal = 1'b1; d_op = 6'd20; end
          3'b001: begin d_legal = 1'b1; d_op = 6'd21; end
          3'b010: begin d_legal = 1'b1; d_op = 6'd22; end
          3'b100: begin d_legal = 1'b1; d_op = 6'd23; end
          3'b101: begin d_legal = 1'b1; d_op = 6'd24; end
          default: ;
        endcase
      end
      7'b0100011: begin
        d_rs1 = rs1_f; d_rs2 = rs2_f; d_imm = imm_s; d_rs1_used = 1'b1; d_rs2_used = 1'b1;
        case (funct3)
          3'b000: begin d_legal = 1'b1; d_op = 6'd25; end
          3'b001: begin d_legal = 1'b1; d_op = 6'd26; end
          3'b010: begin d_legal = 1'b1; d_op = 6'd27; end
          default: ;
        endcase
      end
      7'b0010011: begin
        d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i; d_rs1_used = 1'b1; d_legal = 1'b1;
        case (funct3)
          3'b000: d_op = 6'd30;
          3'b010: d_op = 6'd31;
          3'b011: d_op = 6'd32;
          3'b100: d_op = 6'd33;
          3'b110: d_op = 6'd34;
          3'b111: d_op = 6'd35;
          3'b001: begin d_op = 6'd36; d_imm = imm_sh; d_legal = (funct7 == 7'b0000000); end
          default: begin
            d_imm = imm_sh;
            d_op  = funct7[5] ? 6'd38 : 6'd37;
            d_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      7'b0110011: begin
        d_rd = rd_f; d_rs1 = rs1_f; d_rs2 = rs2_f; d_rs1_used = 1'b1; d_rs2_used = 1'b1;
        // SUB and SRA are the only R-type ops with an alternate funct7
        d_legal = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
        case (funct3)
          3'b000: d_op = funct7[5] ? 6'd41 : 6'd40;
          3'b001: d_op = 6'd42;
          3'b010: d_op = 6'd43;
          3'b011: d_op = 6'd44;
          3'b100: d_op = 6'd45;
          3'b101: d_op = funct7[5] ? 6'd47 : 6'd46;
          3'b110: d_op = 6'd48;
          default: d_op = 6'd49;
        endcase
      end
      default: ;
    endcase
    if (!d_legal) begin
      d_op = ILLEGAL_OP; d_rd = '0; d_rs1 = '0; d_rs2 = '0; d_imm = '0;
      d_rs1_used = 1'b0; d_rs2_used = 1'b0;
    end
  end

  assign dec = '{op: d_op, rd: d_rd, rs1: d_rs1, rs2: d_rs2, imm: d_imm, pc: i_pc,
                 rs1_used: d_rs1_used, rs2_used: d_rs2_used, illegal: ~d_legal};

  state_t state_reg, state_next;
  dec_t   out_reg, skid_reg;
  logic   accept, consume;
  logic   load_out_dec, load_out_skid, load_skid;

  assign o_ready = (state_reg != TWO);
  assign o_valid = (state_reg != EMPTY);
  assign accept  = i_valid & o_ready;
  assign consume = o_valid & i_ready;

  // Next-state and slot load controls; flush overrides every other transition
  always_comb begin
    state_next = state_reg;
    load_out_dec = 1'b0; load_out_skid = 1'b0; load_skid = 1'b0;
    if (i_flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (accept) begin state_next = ONE; load_out_dec = 1'b1; end
        ONE: begin
          if (accept && consume)  load_out_dec = 1'b1;
          else if (accept)        begin state_next = TWO; load_skid = 1'b1; end
          else if (consume)       state_next = EMPTY;
        end
        TWO: if (consume) begin state_next = ONE; load_out_skid = 1'b1; end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= EMPTY;
    else          state_reg <= state_next;
  end

  // Output slot and skid buffer data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      if (load_out_dec)       out_reg <= dec;
      else if (load_out_skid) out_reg <= skid_reg;
      if (load_skid)          skid_reg <= dec;
    end
  end

  assign o_op       = out_reg.op;
  assign o_rd       = out_reg.rd;
  assign o_rs1      = out_reg.rs1;
  assign o_rs2      = out_reg.rs2;
  assign o_imm      = out_reg.imm;
  assign o_pc       = out_reg.pc;
  assign o_rs1_used = out_reg.rs1_used;
  assign o_rs2_used = out_reg.rs2_used;
  assign o_illegal  = out_reg.illegal;

endmodule

// File: tb/tb_id_decode.sv
// Directed bench for id_decode: expected decodes are queued when a word is
// accepted and compared in order as execute consumes them.
module tb_id_decode;

  logic        clk, rst_n, flush, valid, ready;
  logic [31:0] instr, pc;
  logic        o_ready, o_valid, o_rs1_used, o_rs2_used, o_illegal;
  logic [5:0]  o_op;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [31:0] o_imm, o_pc;

  id_decode dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc), .o_valid(o_valid), .i_ready(ready),
    .o_op(o_op), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_pc(o_pc),
    .o_rs1_used(o_rs1_used), .o_rs2_used(o_rs2_used), .o_illegal(o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        u1;
    logic        u2;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                              input logic [31:0] imm, epc, input logic u1, u2, ill);
    mk = '{op: op, rd: rd, rs1: rs1, rs2: rs2, imm: imm, pc: epc, u1: u1, u2: u2, ill: ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] p, input exp_t e);
    valid = 1'b1; instr = w; pc = p; cur_exp = e;
  endtask

  // One clock: score a consume, record an accept, then settle at the falling edge
  task automatic tick();
    logic acc, con;
    exp_t got, want;
    acc = valid && o_ready && !flush;
    con = o_valid && ready && !flush;
    if (con) begin
      got = '{op: o_op, rd: o_rd, rs1: o_rs1, rs2: o_rs2, imm: o_imm, pc: o_pc,
              u1: o_rs1_used, u2: o_rs2_used, ill: o_illegal};
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_output observed pc=%h expected no output", o_pc);
      end
      if (sb.size() != 0) begin
        want = sb.pop_front();
        n_checks++;
        assert (got === want) else begin
          n_fail++;
          $error("FAIL decode observed=%h expected=%h", got, want);
        end
        $display("consume pc=%h op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%0d",
                 got.pc, got.op, got.rd, got.rs1, got.rs2, got.imm, got.ill);
      end
    end
    if (acc) sb.push_back(cur_exp);
    if (flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] add_word(input logic [4:0] rd, rs1, rs2);
    add_word = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  initial begin
    int k, cyc;
    logic [4:0] a, b, c;
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; instr = '0; pc = '0;
    cur_exp = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", {31'b0, o_valid}, 32'd0);
    check("reset_ready", {31'b0, o_ready}, 32'd1);
    check("reset_op", {26'b0, o_op}, 32'd0);
    check("reset_imm", o_imm, 32'd0);
    check("reset_pc", o_pc, 32'd0);
    check("reset_flags", {27'b0, o_rd == 0 && o_rs1 == 0 && o_rs2 == 0, o_rs1_used, o_rs2_used, o_illegal, 1'b0}, 32'd16);
    rst_n = 1'b1;

    // Directed decodes with execute always ready
    ready = 1'b1;
    send(32'h00108093, 32'd0, mk(6'd30, 5'd1, 5'd1, 5'd0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0));
    tick();
    check("addi_latency_valid", {31'b0, o_valid}, 32'd1);
    check("addi_op", {26'b0, o_op}, 32'd30);
    send(32'hFE0086E3, 32'd36, mk(6'd10, 5'd0, 5'd1, 5'd0, 32'hFFFFFFEC, 32'd36, 1'b1, 1'b1, 1'b0));
    tick();
    send(32'h00ABF437, 32'd40, mk(6'd0, 5'd8, 5'd0, 5'd0, 32'h00ABF000, 32'd40, 1'b0, 1'b0, 1'b0));
    tick();
    send(32'hFFDFF0EF, 32'd44, mk(6'd2, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 32'd44, 1'b0, 1'b0, 1'b0));
    tick();
    send(32'h40525193, 32'd48, mk(6'd38, 5'd3, 5'd4, 5'd0, 32'd5, 32'd48, 1'b1, 1'b0, 1'b0));
    tick();
    send(32'h407302B3, 32'd52, mk(6'd41, 5'd5, 5'd6, 5'd7, 32'd0, 32'd52, 1'b1, 1'b1, 1'b0));
    tick();
    send(32'hFF852483, 32'd56, mk(6'd22, 5'd9, 5'd10, 5'd0, 32'hFFFFFFF8, 32'd56, 1'b1, 1'b0, 1'b0));
    tick();
    send(32'h00512423, 32'd60, mk(6'd27, 5'd0, 5'd2, 5'd5, 32'd8, 32'd60, 1'b1, 1'b1, 1'b0));
    tick();
    send(32'h0000000F, 32'd64, mk(6'd63, 5'd0, 5'd0, 5'd0, 32'd0, 32'd64, 1'b0, 1'b0, 1'b1));
    tick();
    send(32'h40109093, 32'd68, mk(6'd63, 5'd0, 5'd0, 5'd0, 32'd0, 32'd68, 1'b0, 1'b0, 1'b1));
    tick();
    valid = 1'b0;
    tick();
    check("directed_drained", sb.size(), 32'd0);

    // Six back-to-back ADDs with execute stalled for the first three cycles
    k = 0; cyc = 0;
    while (k < 6 && cyc < 40) begin
      a = 5'(k + 1); b = 5'(k + 2); c = 5'(k + 3);
      send(add_word(a, b, c), 32'h100 + 32'(4 * k),
           mk(6'd40, a, b, c, 32'd0, 32'h100 + 32'(4 * k), 1'b1, 1'b1, 1'b0));
      ready = (cyc >= 3);
      if (cyc == 2) check("stream_two_ready_low", {31'b0, o_ready}, 32'd0);
      if (o_ready) k++;
      tick();
      cyc++;
    end
    check("stream_all_accepted", k, 32'd6);
    valid = 1'b0; ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin tick(); cyc++; end
    check("stream_drained", sb.size(), 32'd0);
    tick();
    check("stream_no_duplicate", {31'b0, o_valid}, 32'd0);

    // Flush while the skid is full, with a simultaneous input word
    ready = 1'b0;
    send(add_word(5'd1, 5'd2, 5'd3), 32'h200, mk(6'd40, 5'd1, 5'd2, 5'd3, 32'd0, 32'h200, 1'b1, 1'b1, 1'b0));
    tick();
    send(add_word(5'd4, 5'd5, 5'd6), 32'h204, mk(6'd40, 5'd4, 5'd5, 5'd6, 32'd0, 32'h204, 1'b1, 1'b1, 1'b0));
    tick();
    check("flush_pre_ready", {31'b0, o_ready}, 32'd0);
    send(add_word(5'd7, 5'd8, 5'd9), 32'h208, mk(6'd40, 5'd7, 5'd8, 5'd9, 32'd0, 32'h208, 1'b1, 1'b1, 1'b0));
    flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0;
    check("flush_valid", {31'b0, o_valid}, 32'd0);
    check("flush_ready", {31'b0, o_ready}, 32'd1);
    ready = 1'b1;
    send(32'h00108093, 32'h300, mk(6'd30, 5'd1, 5'd1, 5'd0, 32'd1, 32'h300, 1'b1, 1'b0, 1'b0));
    tick();
    valid = 1'b0;
    tick();
    check("flush_after_drained", sb.size(), 32'd0);

    // Asynchronous reset mid-stream while in TWO
    ready = 1'b0;
    send(add_word(5'd10, 5'd11, 5'd12), 32'h380, mk(6'd40, 5'd10, 5'd11, 5'd12, 32'd0, 32'h380, 1'b1, 1'b1, 1'b0));
    tick();
    send(add_word(5'd13, 5'd14, 5'd15), 32'h384, mk(6'd40, 5'd13, 5'd14, 5'd15, 32'd0, 32'h384, 1'b1, 1'b1, 1'b0));
    tick();
    check("rst_pre_ready", {31'b0, o_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'b0, o_valid}, 32'd0);
    check("rst_async_ready", {31'b0, o_ready}, 32'd1);
    check("rst_async_pc", o_pc, 32'd0);
    sb.delete();
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    send(32'h00ABF437, 32'h400, mk(6'd0, 5'd8, 5'd0, 5'd0, 32'h00ABF000, 32'h400, 1'b0, 1'b0, 1'b0));
    tick();
    valid = 1'b0;
    tick();
    check("rst_after_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_decode.md
# id_decode

Decode stage for the wizardCore RV32I pipeline. Accepts 32-bit instruction words and their PCs from instruction fetch and expands each word into opcode ID, register indices, sign-extended immediate and source-use flags, which feed the execute stage. Output goes through a registered valid/ready pipeline slot backed by a one-entry skid buffer, so it sustains one instruction per cycle under backpressure with a registered `o_ready`. Flush discards everything in flight.

## Interface
- `ILLEGAL_OP`, default 63: opcode ID emitted for any word outside the supported subset.
- `i_clk` input 1: clock; all state updates on rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_flush` input 1: discard buffered and incoming instructions (branch redirect).
- `i_valid` input 1: fetch presents `i_instr` and `i_pc`.
- `o_ready` output 1: decode can accept; registered.
- `i_instr` input 32: instruction word.
- `i_pc` input 32: address of `i_instr`.
- `o_valid` output 1: decoded instruction available.
- `i_ready` input 1: execute consumes the decoded instruction.
- `o_op` output 6: opcode ID. LUI=0, AUIPC=1, JAL=2, JALR=3, BEQ..BGEU=10..15, LB,LH,LW,LBU,LHU=20..24, SB,SH,SW=25..27, ADDI..SRAI=30..38, ADD..AND=40..49.
- `o_rd`, `o_rs1`, `o_rs2` output 5 each: register indices. Forced to 0 when the field is unused by the format.
- `o_imm` output 32: decoded immediate; see Operation.
- `o_pc` output 32: PC of the decoded instruction.
- `o_rs1_used`, `o_rs2_used` output 1 each: the instruction reads that source register.
- `o_illegal` output 1: the word is unsupported; `o_op`=`ILLEGAL_OP`.

## Operation
- The combinational decode of `i_instr` uses opcode[6:0], funct3 and funct7[5]. Any mismatch with the RV32I subset listed above sets illegal. FENCE and SYSTEM words are illegal.
- Immediates:
  - I-type: sign-extended [31:20].
  - S-type: sign-extended {[31:25],[11:7]}.
  - B-type: sign-extended {[31],[7],[30:25],[11:8],0}.
  - U-type: {[31:12],12'b0}.
  - J-type: sign-extended {[31],[19:12],[20],[30:21],0}.
  - Shift-immediate: zero-extended shamt [24:20].
  - R-type: 0.
- Shift-immediate funct7 must be 0000000 (SLLI/SRLI) or 0100000 (SRAI only); any other value is illegal.
- R-type funct7 must be 0000000, or 0100000 for SUB/SRA only; any other value is illegal.
- Source use:
  - rs1_used: JALR, branches, loads, stores, OP-IMM, OP.
  - rs2_used: branches, stores, OP.
- An illegal instruction still travels down the pipe with `o_illegal`=1. Its rd/rs1/rs2, imm and use flags are 0.
- Buffer states:
  - EMPTY: no output valid.
  - ONE: output register valid.
  - TWO: output register and skid buffer both valid.
- Accept = `i_valid & o_ready`. Consume = `o_valid & i_ready`.
- Transitions:
  - EMPTY: accept goes to ONE.
  - ONE: accept with consume stays ONE (new word loads the output register). Accept without consume goes to TWO (word goes to skid). Consume only goes to EMPTY.
  - TWO: consume moves skid to output and goes to ONE. Accept is impossible because `o_ready`=0.
- `o_ready` = 1 in EMPTY and ONE, 0 in TWO.
- Flush has priority over everything. The next state is EMPTY, and a word accepted in the same cycle is dropped.
- Ordering is strictly FIFO. No instruction is lost or duplicated.

## Timing
- Reset (asynchronous, any state): EMPTY.
  - `o_valid`=0, `o_ready`=1.
  - `o_op`, `o_rd`, `o_rs1`, `o_rs2`, `o_imm`, `o_pc` = 0.
  - `o_rs1_used`, `o_rs2_used`, `o_illegal` = 0.
- Latency: an accept at edge N gives `o_valid`=1 with decoded fields after edge N, held until consumed.
- Output fields are stable while `o_valid`=1 and `i_ready`=0.
- Throughput: 1 instr/cycle while `i_ready`=1.
- `o_ready` falls the cycle after the skid fills and rises the cycle after the skid drains.
- Flush at edge N: `o_valid`=0 and `o_ready`=1 after N.
- Fetch memory updates `i_instr` on the falling edge. Decode samples on the rising edge only.

## Test plan
- ADDI x1,x1,1 (0x00108093), PC 0 -> one cycle later: `o_op`=30, rd=1, rs1=1, rs2=0, `o_imm`=1, rs1_used=1, rs2_used=0.
- BEQ x1,x0,-20 (0xFE0086E3), PC 36 -> `o_op`=10, rs1=1, rs2=0, `o_imm`=0xFFFFFFEC, both used. LUI x8 (0x00ABF437) -> `o_op`=0, rd=8, `o_imm`=0x00ABF000, no sources used.
- Back-to-back stream of 6 ADDs while `i_ready`=0 for 3 cycles -> state reaches TWO and `o_ready` drops. All 6 appear in order with correct PCs, none lost or duplicated.
- In TWO, assert `i_flush` together with `i_valid` -> next cycle `o_valid`=0, `o_ready`=1. The flushed words and the simultaneous input never appear.
- FENCE 0x0000000F; SLLI with funct7=0100000 (0x40109093) -> `o_illegal`=1, `o_op`=63, imm=0.
- Drop `i_rst_n` asynchronously mid-stream in state TWO -> `o_valid`=0 and `o_ready`=1 immediately. After release, the first accepted word decodes normally.
